// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: fetch constants and the rst > redirect > stall > advance priority encoding
package instr_fetch_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {SEL_RESET, SEL_REDIRECT, SEL_STALL, SEL_ADVANCE} fetch_sel_e;
  function automatic fetch_sel_e fetch_sel(input logic rst, input logic redirect, input logic stall);
    return rst ? SEL_RESET : redirect ? SEL_REDIRECT : stall ? SEL_STALL : SEL_ADVANCE;
  endfunction
endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// fetch_pc_reg: next-fetch PC register with reset/redirect/stall/+4 mux and sticky misalign flag
module fetch_pc_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_q,
  output logic        misalign
);
  fetch_sel_e sel;
  logic [31:0] pc_d;
  logic misalign_d;
  always_comb begin
    sel = fetch_sel(rst, redirect_valid, stall);
    pc_d = sel == SEL_RESET ? RESET_PC :
           sel == SEL_REDIRECT ? {redirect_pc[31:2], 2'b00} :
           sel == SEL_STALL ? pc_q : pc_q + 32'd4;
    misalign_d = sel == SEL_RESET ? 1'b0 :
                 sel == SEL_REDIRECT ? misalign | (|redirect_pc[1:0]) : misalign;
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    misalign <= misalign_d;
  end
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, synchronous-BRAM request tracking and IF/ID register with stall and redirect flush
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]            imem_rdata_i,
  output logic                   if_id_valid_o,
  output logic [31:0]            if_id_instr_o,
  output logic [31:0]            if_id_pc_o,
  output logic [31:0]            if_id_pc_plus4_o,
  output logic                   misalign_o
);
  logic [31:0] pc_q, req_pc_q;
  logic req_valid_q;
  fetch_sel_e sel;
  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .stall(stall_i),
    .redirect_valid(redirect_valid_i),
    .redirect_pc(redirect_pc_i),
    .pc_q(pc_q),
    .misalign(misalign_o)
  );
  always_comb begin
    sel = fetch_sel(rst, redirect_valid_i, stall_i);
    imem_addr_o = stall_i ? req_pc_q[IMEM_ADDR_W+1:2] : pc_q[IMEM_ADDR_W+1:2];
  end
  always_ff @(posedge clk) begin
    if (sel == SEL_RESET) begin
      req_valid_q <= 1'b0;
      req_pc_q <= RESET_PC;
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc_o <= 32'd0;
      if_id_pc_plus4_o <= 32'd4;
    end else if (sel == SEL_REDIRECT) begin
      req_valid_q <= 1'b0;
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end else if (sel == SEL_ADVANCE) begin
      req_pc_q <= pc_q;
      req_valid_q <= 1'b1;
      if_id_valid_o <= req_valid_q;
      if_id_instr_o <= req_valid_q ? imem_rdata_i : NOP_INSTR;
      if_id_pc_o <= req_pc_q;
      if_id_pc_plus4_o <= req_pc_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed fetch/stall/redirect/reset sequence against a mem[i]=i+1 BRAM model
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {logic v; logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4;} exp_t;
  logic clk = 1'b0, rst = 1'b1, stall_i = 1'b0, redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic [13:0] addr0, addr1;
  logic [31:0] rdata0, rdata1, instr0, instr1, pc0, pc1, pc40, pc41;
  logic valid0, valid1, mis0, mis1;
  int checks = 0, errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    rdata0 <= 32'(addr0) + 32'd1;
    rdata1 <= 32'(addr1) + 32'd1;
  end
  instr_fetch_stage dut0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(addr0), .imem_rdata_i(rdata0),
    .if_id_valid_o(valid0), .if_id_instr_o(instr0), .if_id_pc_o(pc0),
    .if_id_pc_plus4_o(pc40), .misalign_o(mis0)
  );
  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
    .if_id_valid_o(valid1), .if_id_instr_o(instr1), .if_id_pc_o(pc1),
    .if_id_pc_plus4_o(pc41), .misalign_o(mis1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic ev, input logic [31:0] epc);
    exp_t e, g;
    stall_i = s;
    redirect_valid_i = r;
    redirect_pc_i = rpc;
    e.v = ev;
    e.instr = ev ? (epc >> 2) + 32'd1 : NOP;
    e.pc = epc;
    e.pc4 = epc + 32'd4;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("valid", {31'd0, valid0}, {31'd0, g.v});
    chk("instr", instr0, g.instr);
    if (g.v) begin
      chk("pc", pc0, g.pc);
      chk("pc_plus4", pc40, g.pc4);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_instr", instr0, NOP);
    chk("rst_pc", pc0, 32'd0);
    chk("rst_pc4", pc40, 32'd4);
    chk("rst_misalign", {31'd0, mis0}, 32'd0);
    chk("rst_addr", {18'd0, addr0}, 32'd0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 1, 32'h4);
    cyc(0, 0, 0, 1, 32'h8);
    stall_i = 1'b1;
    #1;
    chk("stall_addr", {18'd0, addr0}, 32'd3);
    repeat (3) cyc(1, 0, 0, 1, 32'h8);
    cyc(0, 0, 0, 1, 32'hC);
    cyc(0, 0, 0, 1, 32'h10);
    cyc(0, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h40);
    cyc(0, 0, 0, 1, 32'h44);
    cyc(1, 1, 32'h80, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h80);
    chk("misalign_clear", {31'd0, mis0}, 32'd0);
    cyc(0, 1, 32'h42, 0, 0);
    chk("misalign_set", {31'd0, mis0}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h40);
    cyc(0, 0, 0, 1, 32'h44);
    chk("misalign_sticky", {31'd0, mis0}, 32'd1);
    cyc(0, 1, 32'h18, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h18);
    cyc(0, 0, 0, 1, 32'h1C);
    cyc(0, 0, 0, 1, 32'h20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, valid0}, 32'd0);
    chk("mid_rst_instr", instr0, NOP);
    chk("mid_rst_pc4", pc40, 32'd4);
    chk("mid_rst_misalign", {31'd0, mis0}, 32'd0);
    chk("hi_rst_valid", {31'd0, valid1}, 32'd0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk("hi_bubble", {31'd0, valid1}, 32'd0);
    cyc(0, 0, 0, 1, 32'h0);
    chk("hi_valid", {31'd0, valid1}, 32'd1);
    chk("hi_pc", pc1, 32'hFFFF_FFFC);
    chk("hi_instr", instr1, 32'h0000_4000);
    chk("hi_pc4_wrap", pc41, 32'h0);
    cyc(0, 0, 0, 1, 32'h4);
    chk("hi_wrap_pc", pc1, 32'h0);
    chk("hi_wrap_instr", instr1, 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
